vmul_tc_sequencer: RTL
======================

# vmul_tc_sequencer

Multi-cycle controller that time-shares one precision-aware two's-complement unit (4·WIDTH bits, lanes of 8/16/32 bits) across operand A, operand B, and both product halves for the vector Vedic (Urdhva-Tiryakbhyam) multiplier. It accepts MUL/MULH/MULHU/MULSU requests over valid/ready and converts signed operands to magnitudes. It then starts the unsigned multiplier, re-applies sign per lane, and returns the selected low or high lane halves.

## Interface
- WIDTH, 8, chunk width; operands are 4·WIDTH bits, product is 8·WIDTH bits.
- MUL_TIMEOUT, 64, maximum cycles to wait for mul_done before aborting.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid / in_ready  in / out  1  request handshake; transfer when both are high.
- opcode  in  2  00 MUL, 01 MULH, 10 MULHU, 11 MULSU.
- precision  in  2  00 8-bit lanes, 01 16-bit, 10 32-bit, 11 treated as 00.
- operand_a, operand_b  in  4·WIDTH  packed lane operands.
- tc_precision  out  2  precision driven to the shared TC unit.
- tc_operand  out  4·WIDTH  TC unit input.
- tc_result  in  4·WIDTH  TC unit output, combinational, same cycle.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a, mul_b  out  4·WIDTH  magnitude operands, held stable from mul_start until mul_done.
- mul_done  in  1  multiplier completion strobe.
- mul_product  in  8·WIDTH  unsigned product; lane i occupies bits [2L·i +: 2L].
- out_valid / out_ready  out / in  1  result handshake.
- result  out  4·WIDTH  lane i result at [L·i +: L].
- err  out  1  valid with out_valid; 1 means multiplier timeout.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- Lane width L = 8, 16 or 32 by precision.
- Sign A of lane i is MSB of lane i when opcode ∈ {00, 01, 11}; sign B of lane i is MSB of lane i when opcode ∈ {00, 01}. Neg of lane i = sign A XOR sign B.
- FSM: IDLE → TC_A → TC_B → MUL_START → MUL_WAIT → TC_LO → TC_HI → DONE → IDLE.
- Every state is visited for every opcode; the latency is fixed.
- IDLE: in_ready = 1. On transfer, register opcode, precision, operands, and the per-lane sign/neg flags.
- TC_A: tc_operand = a_reg, tc_precision = prec. mul_a lane i ← tc_result lane if sign A of lane i, else a_reg lane.
- TC_B: same as TC_A for operand B into mul_b.
- MUL_START: assert mul_start for exactly this cycle. Clear the timeout counter.
- MUL_WAIT: wait for mul_done, then capture mul_product.
  - A mul_done seen in the MUL_START cycle is ignored.
  - If the counter reaches MUL_TIMEOUT, go to DONE with result = 0 and err = 1.
- Product passes run on the 4·WIDTH-bit halves P_lo = product[4W-1:0] and P_hi = product[8W-1:4W].
- Product-pass precision: 8-bit lanes → 01; 16-bit → 10; 32-bit → 10.
- TC_LO: tc_operand = P_lo. Each negated 2L lane takes tc_result, else P_lo.
- TC_HI: tc_operand = P_hi.
  - For 8- and 16-bit lanes, negated lanes take tc_result.
  - For 32-bit lanes, the negated lane takes tc_result if P_lo == 0, else ~P_hi (borrow rule).
- Result selection: opcode 00 takes the low L bits of each signed 2L product; otherwise it takes the high L bits.
- DONE: out_valid = 1 and result/err are held stable until out_ready. On the handshake, go to IDLE.
- Requests do not overlap; in_ready = 0 outside IDLE.
- Reset, including mid-operation: state → IDLE and the in-flight request is discarded.
  - All outputs reset to 0: out_valid, mul_start, busy, err, result, mul_a, mul_b, tc_operand, tc_precision.
  - in_ready = 0 while rst is high and 1 on the first cycle after it.

## Timing
- Cycle numbering: request accepted at cycle 0; TC_A at 1, TC_B at 2, mul_start at 3.
- The multiplier asserts mul_done at 3+M, with M ≥ 1.
- TC_LO at 4+M, TC_HI at 5+M, out_valid from 6+M. Accept-to-result latency is 6+M.
- Timeout path: out_valid is asserted on the cycle after the counter hits MUL_TIMEOUT.
- Back-to-back: the earliest next acceptance is the cycle after the out handshake.
- tc_* outputs are registered state-decoded values; tc_result is sampled in the same state cycle.

## Test plan
- Precision 10, MUL, a = 0xFFFFFFFD, b = 0x00000005, M = 3 → result 0xFFFFFFF1, err = 0, out_valid at cycle 9.
- Precision 10, MULSU, a = 0xFFFFFFFF, b = 0xFFFFFFFF → internal product 0xFFFFFFFF_00000001 (borrow rule), result 0xFFFFFFFF.
- Precision 00, MUL, a = 0x807FFF02, b = 0x0202FF03 → result 0x00FE0106. Repeat with precision 11 → identical result.
- Precision 01, MULHU, a = 0xFFFF0002, b = 0xFFFF0003 → result 0xFFFE0000; mul_a = operand_a unchanged.
- mul_done never asserted, MUL_TIMEOUT = 64 → err = 1, result = 0. Hold out_ready low 5 cycles → out_valid/result stable, in_ready = 0 throughout.
- Assert rst during MUL_WAIT → next cycle busy = 0, in_ready = 1, no out_valid. A late mul_done is ignored. A new request completes correctly.

Source files
------------

// File: rtl/vmul_tc_sequencer.sv
// vmul_tc_sequencer: shares one lane-wise two's-complement unit across operand A, operand B
// and both product halves around an unsigned vector Vedic multiplier.
module vmul_tc_sequencer #(
  parameter int WIDTH       = 8,
  parameter int MUL_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           opcode,
  input  logic [1:0]           precision,
  input  logic [4*WIDTH-1:0]   operand_a,
  input  logic [4*WIDTH-1:0]   operand_b,
  output logic [1:0]           tc_precision,
  output logic [4*WIDTH-1:0]   tc_operand,
  input  logic [4*WIDTH-1:0]   tc_result,
  output logic                 mul_start,
  output logic [4*WIDTH-1:0]   mul_a,
  output logic [4*WIDTH-1:0]   mul_b,
  input  logic                 mul_done,
  input  logic [8*WIDTH-1:0]   mul_product,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*WIDTH-1:0]   result,
  output logic                 err,
  output logic                 busy
);
  localparam int N  = 4 * WIDTH;
  localparam int NB = N / 8;
  localparam int CW = $clog2(MUL_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(MUL_TIMEOUT);
  typedef enum logic [2:0] {IDLE, TC_A, TC_B, MUL_START, MUL_WAIT, TC_LO, TC_HI, DONE} state_t;
  state_t         r_state;
  logic [1:0]     r_op, r_prec, r_tc_prec;
  logic [N-1:0]   r_a, r_b, r_lo, r_mul_a, r_mul_b, r_tc_op, r_result;
  logic [2*N-1:0] r_prod;
  logic [NB-1:0]  r_sa, r_sb, r_neg;
  logic [CW-1:0]  r_cnt;
  logic           r_mul_start, r_err;
  logic [1:0]     w_prec, w_pprec;
  logic [NB-1:0]  w_sa, w_sb;
  logic [N-1:0]   w_ma, w_mb, w_lo, w_hi, w_r8, w_r16, w_r32, w_res;
  logic [2*N-1:0] w_s;
  logic           w_lo_zero;
  assign w_prec    = precision == 2'b11 ? 2'b00 : precision;
  assign w_pprec   = r_prec == 2'b00 ? 2'b01 : 2'b10;
  assign w_lo_zero = r_prod[N-1:0] == '0;
  assign w_s       = {w_hi, r_lo};
  assign w_res     = r_prec == 2'b10 ? w_r32 : r_prec == 2'b01 ? w_r16 : w_r8;
  // Sign/neg flags are kept per byte, replicated across every byte of a lane
  always_comb begin
    w_sa = '0;
    w_sb = '0;
    for (int j = 0; j < NB; j++) begin
      w_sa[j] = opcode != 2'b10 && (w_prec == 2'b10 ? operand_a[8*(j|3)+7] :
                                    w_prec == 2'b01 ? operand_a[8*(j|1)+7] : operand_a[8*j+7]);
      w_sb[j] = !opcode[1] && (w_prec == 2'b10 ? operand_b[8*(j|3)+7] :
                               w_prec == 2'b01 ? operand_b[8*(j|1)+7] : operand_b[8*j+7]);
    end
  end
  // Product byte g belongs to the operand lane that holds byte g/2
  always_comb begin
    w_ma = '0;
    w_mb = '0;
    w_lo = '0;
    w_hi = '0;
    for (int j = 0; j < NB; j++) begin
      w_ma[8*j +: 8] = r_sa[j] ? tc_result[8*j +: 8] : r_a[8*j +: 8];
      w_mb[8*j +: 8] = r_sb[j] ? tc_result[8*j +: 8] : r_b[8*j +: 8];
      w_lo[8*j +: 8] = r_neg[j/2] ? tc_result[8*j +: 8] : r_prod[8*j +: 8];
      w_hi[8*j +: 8] = !r_neg[(j+NB)/2] ? r_prod[N+8*j +: 8] :
                       r_prec == 2'b10 && !w_lo_zero ? ~r_prod[N+8*j +: 8] : tc_result[8*j +: 8];
    end
  end
  always_comb begin
    w_r8  = '0;
    w_r16 = '0;
    w_r32 = '0;
    for (int i = 0; i < N/8; i++)
      w_r8[8*i +: 8] = r_op != 2'b00 ? w_s[16*i+8 +: 8] : w_s[16*i +: 8];
    for (int i = 0; i < N/16; i++)
      w_r16[16*i +: 16] = r_op != 2'b00 ? w_s[32*i+16 +: 16] : w_s[32*i +: 16];
    for (int i = 0; i < N/32; i++)
      w_r32[32*i +: 32] = r_op != 2'b00 ? w_s[64*i+32 +: 32] : w_s[64*i +: 32];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mul_start <= 1'b0;
      r_err       <= 1'b0;
      r_result    <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_tc_op     <= '0;
      r_tc_prec   <= '0;
      r_cnt       <= '0;
    end else begin
      r_mul_start <= 1'b0;
      case (r_state)
        IDLE: if (in_valid) begin
          r_op      <= opcode;
          r_prec    <= w_prec;
          r_a       <= operand_a;
          r_b       <= operand_b;
          r_sa      <= w_sa;
          r_sb      <= w_sb;
          r_neg     <= w_sa ^ w_sb;
          r_tc_op   <= operand_a;
          r_tc_prec <= w_prec;
          r_state   <= TC_A;
        end
        TC_A: begin
          r_mul_a <= w_ma;
          r_tc_op <= r_b;
          r_state <= TC_B;
        end
        TC_B: begin
          r_mul_b     <= w_mb;
          r_mul_start <= 1'b1;
          r_state     <= MUL_START;
        end
        MUL_START: begin
          r_cnt   <= '0;
          r_state <= MUL_WAIT;
        end
        MUL_WAIT: if (mul_done) begin
          r_prod    <= mul_product;
          r_tc_op   <= mul_product[N-1:0];
          r_tc_prec <= w_pprec;
          r_state   <= TC_LO;
        end else if (r_cnt == TMO) begin
          r_result <= '0;
          r_err    <= 1'b1;
          r_state  <= DONE;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        TC_LO: begin
          r_lo    <= w_lo;
          r_tc_op <= r_prod[2*N-1:N];
          r_state <= TC_HI;
        end
        TC_HI: begin
          r_result <= w_res;
          r_err    <= 1'b0;
          r_state  <= DONE;
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign in_ready     = r_state == IDLE && !rst;
  assign busy         = r_state != IDLE;
  assign out_valid    = r_state == DONE;
  assign mul_start    = r_mul_start;
  assign mul_a        = r_mul_a;
  assign mul_b        = r_mul_b;
  assign tc_operand   = r_tc_op;
  assign tc_precision = r_tc_prec;
  assign result       = r_result;
  assign err          = r_err;
endmodule
